// File: rtl/div_req_arbiter.sv
// rtl/div_req_arbiter.sv - round-robin arbiter sharing one restoring divider among NREQ requesters
//
// Purpose:
//   Picks one pending requester (round-robin), latches its operands, starts the
//   shared divider and returns quotient/remainder tagged with the requester ID.
//   A zero divisor is answered directly without starting the divider, and a
//   watchdog aborts the wait if the divider never reports done.
//
// Ports:
//   i_clk         clock, rising edge
//   rst_n         synchronous active-low reset
//   req           per-requester request level
//   req_dividend  packed dividends, requester i at [i*WIDTH +: WIDTH]
//   req_divisor   packed divisors, same layout
//   gnt           one-hot acceptance pulse
//   busy          high whenever not IDLE
//   div_start     one-cycle divider start pulse
//   div_dividend  latched dividend to the divider
//   div_divisor   latched divisor to the divider
//   div_done      divider completion (only looked at in WAIT)
//   div_q, div_r  divider results
//   rsp_valid     one-cycle response pulse
//   rsp_id        requester being answered
//   rsp_q, rsp_r  quotient / remainder of the response
//   rsp_dz        divide-by-zero flag
//   rsp_to        watchdog timeout flag

module div_req_arbiter #(
  parameter int WIDTH   = 4,
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                  i_clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_dividend,
  input  logic [NREQ*WIDTH-1:0] req_divisor,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  div_start,
  output logic [WIDTH-1:0]      div_dividend,
  output logic [WIDTH-1:0]      div_divisor,
  input  logic                  div_done,
  input  logic [WIDTH-1:0]      div_q,
  input  logic [WIDTH-1:0]      div_r,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_q,
  output logic [WIDTH-1:0]      rsp_r,
  output logic                  rsp_dz,
  output logic                  rsp_to
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [7:0]      TO_LAST  = 8'(TIMEOUT - 1);
  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

  state_t           r_state;
  state_t           w_next;

  logic [IDW-1:0]   r_rr_ptr;
  logic [IDW-1:0]   r_id;
  logic [WIDTH-1:0] r_dividend;
  logic [WIDTH-1:0] r_divisor;
  logic             r_dz;
  logic [7:0]       r_cnt;
  logic [IDW-1:0]   r_rsp_id;
  logic [WIDTH-1:0] r_rsp_q;
  logic [WIDTH-1:0] r_rsp_r;
  logic             r_rsp_dz;
  logic             r_rsp_to;

  logic             w_any;
  logic [IDW-1:0]   w_win_id;
  int               w_scan;
  logic [WIDTH-1:0] w_sel_dividend;
  logic [WIDTH-1:0] w_sel_divisor;
  logic             w_sel_dz;
  logic             w_to_hit;

  // Round-robin pick: scan from farthest to nearest after rr_ptr so the
  // nearest set bit is written last and therefore wins.
  always_comb begin
    w_any    = 1'b0;
    w_win_id = '0;
    w_scan   = 0;
    for (int i = NREQ; i >= 1; i--) begin
      w_scan = (int'(r_rr_ptr) + i) % NREQ;
      if (req[w_scan[IDW-1:0]]) begin
        w_any    = 1'b1;
        w_win_id = w_scan[IDW-1:0];
      end
    end
  end

  assign w_sel_dividend = req_dividend[int'(w_win_id)*WIDTH +: WIDTH];
  assign w_sel_divisor  = req_divisor[int'(w_win_id)*WIDTH +: WIDTH];
  assign w_sel_dz       = (w_sel_divisor == '0);
  assign w_to_hit       = (r_cnt == TO_LAST);

  // State register
  always_ff @(posedge i_clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_next = w_sel_dz ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: w_next = S_WAIT;
      S_WAIT: begin
        // done wins over the watchdog when both land in the same cycle
        if (div_done || w_to_hit) begin
          w_next = S_RESP;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand, watchdog and response registers
  always_ff @(posedge i_clk) begin
    if (!rst_n) begin
      r_rr_ptr   <= IDW'(NREQ - 1);
      r_id       <= '0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_dz       <= 1'b0;
      r_cnt      <= '0;
      r_rsp_id   <= '0;
      r_rsp_q    <= '0;
      r_rsp_r    <= '0;
      r_rsp_dz   <= 1'b0;
      r_rsp_to   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_id       <= w_win_id;
            r_dividend <= w_sel_dividend;
            r_divisor  <= w_sel_divisor;
            r_dz       <= w_sel_dz;
            // zero divisor skips the divider; its response is formed here
            if (w_sel_dz) begin
              r_rsp_id <= w_win_id;
              r_rsp_q  <= '1;
              r_rsp_r  <= w_sel_dividend;
              r_rsp_dz <= 1'b1;
              r_rsp_to <= 1'b0;
            end
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 8'd1;
          if (div_done) begin
            r_rsp_id <= r_id;
            r_rsp_q  <= div_q;
            r_rsp_r  <= div_r;
            r_rsp_dz <= 1'b0;
            r_rsp_to <= 1'b0;
          end else if (w_to_hit) begin
            r_rsp_id <= r_id;
            r_rsp_q  <= '0;
            r_rsp_r  <= '0;
            r_rsp_dz <= 1'b0;
            r_rsp_to <= 1'b1;
          end
        end
        S_RESP: begin
          r_rr_ptr <= r_id;
          r_cnt    <= '0;
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs
  always_comb begin
    gnt       = '0;
    busy      = (r_state != S_IDLE);
    div_start = (r_state == S_ISSUE);
    rsp_valid = (r_state == S_RESP);
    // dz requests are acknowledged in the response cycle itself
    if ((r_state == S_ISSUE) || ((r_state == S_RESP) && r_dz)) begin
      gnt = ONE_HOT0 << r_id;
    end
  end

  assign div_dividend = r_dividend;
  assign div_divisor  = r_divisor;
  assign rsp_id       = r_rsp_id;
  assign rsp_q        = r_rsp_q;
  assign rsp_r        = r_rsp_r;
  assign rsp_dz       = r_rsp_dz;
  assign rsp_to       = r_rsp_to;

endmodule

// File: doc/div_req_arbiter.md
Name: div_req_arbiter

Overview:
- Shares one unsigned restoring-divider datapath/controller pair among NREQ requesters.
- Round-robin arbitration; latches the winner's operands and pulses the divider start.
- Waits for divider done, then returns quotient/remainder tagged with the requester ID.
- Short-circuits divide-by-zero and enforces a watchdog timeout on the divider.

Parameters:
- WIDTH, 4, operand/result width (matches divider width).
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester ID width (must be at least log2(NREQ)).
- TIMEOUT, 16, max WAIT cycles before abort (1..255).

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req  in  NREQ  per-requester request level.
- req_dividend  in  NREQ*WIDTH  packed; requester i occupies bits [i*WIDTH +: WIDTH].
- req_divisor  in  NREQ*WIDTH  packed, same layout.
- gnt  out  NREQ  one-hot one-cycle acceptance pulse.
- busy  out  1  high in any state other than IDLE.
- div_start  out  1  one-cycle start pulse to the divider.
- div_dividend  out  WIDTH  latched dividend, stable from ISSUE through WAIT.
- div_divisor  out  WIDTH  latched divisor, stable from ISSUE through WAIT.
- div_done  in  1  divider completion; sampled only in WAIT.
- div_q  in  WIDTH  divider quotient; valid when div_done=1.
- div_r  in  WIDTH  divider remainder; valid when div_done=1.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_id  out  IDW  ID of the requester being answered.
- rsp_q  out  WIDTH  quotient result.
- rsp_r  out  WIDTH  remainder result.
- rsp_dz  out  1  divide-by-zero flag.
- rsp_to  out  1  timeout flag.

Behaviour:
- Reset: rst_n=0 at a clock edge forces the following, including mid-operation:
  - state=IDLE; rr_ptr=NREQ-1, so requester 0 has first priority.
  - Watchdog counter=0; latched operands=0.
  - Outputs gnt, busy, div_start, div_dividend, div_divisor, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dz, rsp_to all 0.
  - div_done is ignored while rst_n=0.
- State IDLE: if any req bit is set, choose the winner as the first set bit scanning rr_ptr+1, rr_ptr+2, ... modulo NREQ.
  - Latch the winner's operands and ID.
  - If the divisor is nonzero, go to ISSUE; otherwise go to RESP with the dz path.
  - req is sampled only in IDLE.
- State ISSUE (1 cycle): gnt[winner]=1 and div_start=1, then go to WAIT.
- State WAIT:
  - Watchdog counter increments each cycle.
  - If div_done=1: latch div_q/div_r and go to RESP (done has priority over timeout in the same cycle).
  - Else if count==TIMEOUT-1: go to RESP with the to path.
  - div_start=0 throughout WAIT.
- State RESP (1 cycle): rsp_valid=1 with the latched results, then go to IDLE.
  - On entry to IDLE: rr_ptr=winner and the counter clears.
- Response values:
  - Normal: rsp_q=div_q, rsp_r=div_r, rsp_dz=0, rsp_to=0.
  - Divide-by-zero: rsp_q=all ones, rsp_r=dividend, rsp_dz=1. gnt[winner] pulses in this RESP cycle, so gnt and rsp_valid are coincident; the divider is never started.
  - Timeout: rsp_q=0, rsp_r=0, rsp_to=1.
  - rsp_* fields hold their last values when rsp_valid=0.
- Latency, normal path: IDLE accept at cycle 0; gnt/div_start at cycle 1; done seen at cycle k≥2; rsp_valid at k+1; next accept no earlier than k+2.
- Latency, dz path: rsp_valid at cycle 1.
- Requesters must hold req and operands stable until gnt, then drop req.
  - req still high in the IDLE cycle after RESP counts as a new request.
  - The rotated pointer ensures other pending requesters win first.
- Operand changes after gnt have no effect.
- div_done arriving outside WAIT is ignored, including a late done after a timeout.
- busy=1 in ISSUE, WAIT and RESP.

Test Plan:
- Single request: req[0]=1, 13/3; divider model takes 6 cycles. Required: gnt[0] at cycle 1 with div_start, div_dividend=13, div_divisor=3; rsp_valid with rsp_id=0, q=4, r=1, dz=0, to=0.
- Divide-by-zero: req[2]=1, 9/0. Required: gnt[2] and rsp_valid both at cycle 1; q=15, r=9, dz=1; div_start never asserted.
- Round-robin: all four req held from reset, each dropped after its gnt. Required: grant order 0,1,2,3. Re-raising req[0] with req[3] pending after the 0 grant gives order 3 then 0.
- Timeout: divider model never asserts done, TIMEOUT=16. Required: rsp_valid 16 cycles after entering WAIT with to=1, q=0, r=0. A late div_done in IDLE causes no response.
- Reset mid-WAIT: rst_n=0 for 1 cycle during WAIT. Required: next cycle state=IDLE, all outputs 0, no rsp_valid for the aborted request; the next request from requester 0 is granted first.
- Done/timeout collision: div_done asserted on the cycle count==TIMEOUT-1. Required: normal response with to=0 and the divider's q/r.
